// File: rtl/sys_array_pkg.sv
// Shared types and constants for the systolic-array sequencer.
package sys_array_pkg;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_N         = 3;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_ARRAY_LAT = 10;

  typedef enum logic [1:0] {LOAD, CLEAR, RUN, HOLD} ctrl_state_t;

  // LSB of element idx in a flattened bus; element 0 sits in the MSBs.
  function automatic int elem_lsb(input int idx, input int ne, input int w);
    return (ne - 1 - idx) * w;
  endfunction
endpackage

// File: rtl/coef_buf.sv
// Kernel register file with per-element written mask; writes only land while wr_gate is high.
module coef_buf import sys_array_pkg::*; #(
  parameter int NUM_LANES = 9,
  parameter int VEC_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_gate,
  input  logic                       wr_en,
  input  logic [3:0]                 wr_addr,
  input  logic [VEC_W-1:0]           wr_data,
  output logic [NUM_LANES*VEC_W-1:0] kernel,
  output logic                       kernel_valid
);
  logic [NUM_LANES-1:0] mask;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [VEC_W-1:0] q;
    logic             seen;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q    <= '0;
        seen <= 1'b0;
      end else if (wr_gate && wr_en && wr_addr == 4'(i)) begin
        q    <= wr_data;
        seen <= 1'b1;
      end
    end
    assign kernel[elem_lsb(i, NUM_LANES, VEC_W) +: VEC_W] = q;
    assign mask[i] = seen;
  end

  assign kernel_valid = &mask;
endmodule

// File: rtl/sys_array_ctrl.sv
// Sequencer for the 3x3 systolic array: gathers a window, clears the array,
// waits its fixed latency and hands the captured result out on valid/ready.
module sys_array_ctrl import sys_array_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N         = DEF_N,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int ARRAY_LAT = DEF_ARRAY_LAT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  k_wr_en,
  input  logic [3:0]            k_wr_addr,
  input  logic [DATA_W-1:0]     k_wr_data,
  output logic                  kernel_valid,
  input  logic                  win_valid,
  output logic                  win_ready,
  input  logic [DATA_W-1:0]     win_data,
  output logic [N*N*DATA_W-1:0] arr_data_a,
  output logic [N*N*DATA_W-1:0] arr_data_k,
  output logic                  arr_clr,
  input  logic [ACC_W-1:0]      arr_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_W-1:0]      res_data,
  output logic                  busy
);
  localparam int NE = N * N;
  localparam int CW = $clog2(NE);
  localparam int LW = $clog2(ARRAY_LAT + 1);

  ctrl_state_t                  state, state_nx;
  logic [CW-1:0]                cnt;
  logic [LW-1:0]                lat_cnt;
  logic [NE-1:0][DATA_W-1:0]    win_buf;
  logic                         beat;

  // Handshake and status are pure state decodes, no input-to-output paths.
  assign win_ready  = (state == LOAD) && kernel_valid;
  assign beat       = win_valid && win_ready;
  assign arr_clr    = (state == CLEAR);
  assign busy       = (state != LOAD);
  assign arr_data_a = win_buf;

  coef_buf #(.NUM_LANES(NE), .VEC_W(DATA_W)) u_coef (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_gate      ((state == LOAD) || (state == HOLD)),
    .wr_en        (k_wr_en),
    .wr_addr      (k_wr_addr),
    .wr_data      (k_wr_data),
    .kernel       (arr_data_k),
    .kernel_valid (kernel_valid)
  );

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (beat && cnt == CW'(NE - 1)) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN:     if (lat_cnt == '0) state_nx = HOLD;
      HOLD:    if (res_ready) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LOAD;
      cnt       <= '0;
      lat_cnt   <= '0;
      win_buf   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state <= state_nx;
      if (beat) begin
        win_buf[CW'(NE - 1) - cnt] <= win_data;
        cnt <= (cnt == CW'(NE - 1)) ? '0 : cnt + CW'(1);
      end
      if (state == CLEAR)
        lat_cnt <= LW'(ARRAY_LAT - 1);
      else if (state == RUN && lat_cnt != '0)
        lat_cnt <= lat_cnt - LW'(1);
      if (state == RUN && lat_cnt == '0) begin
        res_data  <= arr_result;
        res_valid <= 1'b1;
      end else if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sys_array_ctrl.sv
// Randomized bench for sys_array_ctrl with a transaction-level reference model.
module tb_sys_array_ctrl;
  localparam int LAT = 10;

  logic         clk, reset_n;
  logic         k_wr_en;
  logic [3:0]   k_wr_addr;
  logic [15:0]  k_wr_data;
  logic         kernel_valid;
  logic         win_valid, win_ready;
  logic [15:0]  win_data;
  logic [143:0] arr_data_a, arr_data_k;
  logic         arr_clr;
  logic [31:0]  arr_result;
  logic         res_valid, res_ready;
  logic [31:0]  res_data;
  logic         busy;

  int total, bad;
  shortint     kern[9];
  shortint     kinit[9];
  logic [8:0]  kmask;
  bit          pend_en;
  logic [3:0]  pend_a;
  shortint     pend_d;
  logic [31:0] exp_dot;
  logic [31:0] junk = 32'h0;
  int          clr_age = -1;

  sys_array_ctrl dut (
    .clk(clk), .reset_n(reset_n), .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr),
    .k_wr_data(k_wr_data), .kernel_valid(kernel_valid), .win_valid(win_valid),
    .win_ready(win_ready), .win_data(win_data), .arr_data_a(arr_data_a),
    .arr_data_k(arr_data_k), .arr_clr(arr_clr), .arr_result(arr_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array stand-in: result is only meaningful LAT cycles after the clear pulse.
  always @(posedge clk) begin
    junk <= $urandom;
    if (!reset_n)      clr_age <= -1;
    else if (arr_clr)  clr_age <= 0;
    else if (clr_age >= 0) clr_age <= clr_age + 1;
  end
  assign arr_result = (clr_age == LAT - 1) ? exp_dot : junk;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] pack9(input shortint e[9]);
    logic [143:0] r;
    for (int i = 0; i < 9; i++) r[(8 - i) * 16 +: 16] = e[i];
    return r;
  endfunction

  function automatic logic [31:0] dot9(input shortint a[9], input shortint b[9]);
    longint s = 0;
    for (int i = 0; i < 9; i++) s += longint'(a[i]) * longint'(b[i]);
    return s[31:0];
  endfunction

  task automatic kdrive(input logic [3:0] a, input shortint d, input bit allowed);
    k_wr_en = 1'b1; k_wr_addr = a; k_wr_data = d;
    pend_en = allowed; pend_a = a; pend_d = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (pend_en && pend_a < 4'd9) begin
      kern[pend_a]  = pend_d;
      kmask[pend_a] = 1'b1;
    end
    pend_en = 1'b0;
    k_wr_en = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_kv", kernel_valid, 0);
    chk("rst_ready", win_ready, 0);
    chk("rst_a", arr_data_a, 0);
    chk("rst_k", arr_data_k, 0);
    chk("rst_clr", arr_clr, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_res", res_data, 0);
    chk("rst_busy", busy, 0);
  endtask

  // gap: 0 always valid, 1 toggling, 2 random. rst_at: RUN cycle index for reset, -1 none.
  task automatic run_window(input shortint w[9], input int gap, input int bp,
                            input bit krun, input bit khold, input bit kload, input int rst_at);
    int idx = 0;
    int n = 0;
    bit v;
    logic [143:0] a_exp;
    while (idx < 9) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
      win_valid = v;
      win_data  = w[idx];
      if (kload && $urandom_range(0, 3) == 0)
        kdrive(4'($urandom_range(0, 15)), shortint'($urandom), 1'b1);
      chk("load_ready", win_ready, &kmask);
      chk("load_busy", busy, 0);
      chk("load_clr", arr_clr, 0);
      chk("load_rv", res_valid, 0);
      tick();
      if (v) idx++;
      n++;
      if (n > 200) begin
        chk("beat_timeout", idx, 9);
        win_valid = 1'b0;
        return;
      end
    end
    a_exp   = pack9(w);
    exp_dot = dot9(kern, w);
    win_valid = 1'b1;
    win_data  = 16'(w[8] + 1);
    chk("clr_pulse", arr_clr, 1);
    chk("clr_busy", busy, 1);
    chk("clr_ready", win_ready, 0);
    chk("clr_rv", res_valid, 0);
    chk("win_pack", arr_data_a, a_exp);
    chk("kern_pack", arr_data_k, pack9(kern));
    for (int r = 0; r < LAT; r++) begin
      if (krun && r == 2) kdrive(4'd0, 16'sd5, 1'b0);
      tick();
      chk("run_clr", arr_clr, 0);
      chk("run_busy", busy, 1);
      chk("run_ready", win_ready, 0);
      chk("run_rv", res_valid, 0);
      chk("run_a", arr_data_a, a_exp);
      chk("run_k", arr_data_k, pack9(kern));
      if (r == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk_reset();
        kmask = '0;
        for (int i = 0; i < 9; i++) kern[i] = 0;
        tick(); tick();
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
          tick();
          chk("post_rst_rv", res_valid, 0);
          chk("post_rst_kv", kernel_valid, 0);
          chk("post_rst_ready", win_ready, 0);
          chk("post_rst_busy", busy, 0);
        end
        win_valid = 1'b0;
        return;
      end
    end
    tick();
    chk("res_rise", res_valid, 1);
    chk("res_data", res_data, exp_dot);
    chk("res_busy", busy, 1);
    chk("res_ready_lo", win_ready, 0);
    for (int b = 0; b < bp; b++) begin
      res_ready = 1'b0;
      if (khold && b == 0) kdrive(4'd0, 16'sd5, 1'b1);
      tick();
      chk("hold_rv", res_valid, 1);
      chk("hold_res", res_data, exp_dot);
      chk("hold_ready", win_ready, 0);
      chk("hold_busy", busy, 1);
      chk("hold_a", arr_data_a, a_exp);
      chk("hold_k", arr_data_k, pack9(kern));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    win_valid = 1'b0;
    chk("ack_rv", res_valid, 0);
    chk("ack_busy", busy, 0);
    chk("ack_ready", win_ready, &kmask);
  endtask

  initial begin
    shortint w[9];
    total = 0; bad = 0;
    reset_n = 1'b0; k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0;
    win_valid = 1'b0; win_data = '0; res_ready = 1'b0;
    pend_en = 1'b0; pend_a = '0; pend_d = 0;
    exp_dot = '0; kmask = '0;
    for (int i = 0; i < 9; i++) kern[i] = 0;
    kinit = '{1, 0, -1, 1, 0, -1, 1, 0, -1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    reset_n = 1'b1;
    tick();
    chk_reset();

    // kernel gate: no window beats until all nine kernel slots are written
    for (int i = 0; i < 8; i++) begin
      win_valid = 1'b1;
      win_data  = 16'hBEEF;
      kdrive(4'(i), kinit[i], 1'b1);
      chk("gate_ready", win_ready, 0);
      chk("gate_kv", kernel_valid, 0);
      tick();
    end
    chk("gate_ready7", win_ready, &kmask);
    kdrive(4'd8, kinit[8], 1'b1);
    tick();
    chk("gate_kv8", kernel_valid, 1);
    chk("gate_ready8", win_ready, 1);
    chk("gate_k", arr_data_k, pack9(kern));

    for (int i = 0; i < 9; i++) w[i] = shortint'(i + 1);
    run_window(w, 0, 0, 1'b0, 1'b0, 1'b0, -1);

    for (int i = 0; i < 9; i++) w[i] = shortint'($urandom);
    run_window(w, 0, 20, 1'b0, 1'b1, 1'b0, -1);

    for (int i = 0; i < 9; i++) w[i] = shortint'(i + 10);
    run_window(w, 1, 0, 1'b1, 1'b0, 1'b0, -1);

    for (int t = 0; t < 6; t++) begin
      int bp;
      bp = $urandom_range(0, 5);
      for (int i = 0; i < 9; i++) w[i] = shortint'($urandom);
      run_window(w, $urandom_range(0, 2), bp, 1'($urandom_range(0, 1)),
                 (bp > 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1, -1);
    end

    for (int i = 0; i < 9; i++) w[i] = shortint'($urandom);
    run_window(w, 0, 0, 1'b0, 1'b0, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sys_array_ctrl.md
# sys_array_ctrl

Sequencer for the 3x3 systolic convolution array (`sys_array`). It holds a kernel buffer written through a simple write port and collects a 3x3 input window from a valid/ready stream. It drives both as flattened 144-bit buses into the array, clears the array accumulators, waits the fixed array latency, then captures the 32-bit result and presents it on a valid/ready output. It sits between the stream source (line buffer/DMA) and `sys_array`. It replaces the hand-timed reset/wait sequencing currently done in simulation.

## Interface
- `DATA_W`, 16: element width, signed two's complement.
- `N`, 3: window/kernel dimension; N*N = 9 elements.
- `ACC_W`, 32: array result width.
- `ARRAY_LAT`, 10: cycles from array clear release to `arr_result` valid.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `k_wr_en`  in  1: kernel element write strobe.
- `k_wr_addr`  in  4: kernel element index 0..8, row-major.
- `k_wr_data`  in  DATA_W: kernel element.
- `kernel_valid`  out  1: all 9 kernel elements written since reset.
- `win_valid`  in  1: window stream beat valid.
- `win_ready`  out  1: window stream beat accepted when both high.
- `win_data`  in  DATA_W: window element, row-major order.
- `arr_data_a`  out  N*N*DATA_W: flattened window to array.
- `arr_data_k`  out  N*N*DATA_W: flattened kernel to array.
- `arr_clr`  out  1: active-high synchronous clear to the array (drives its `reset`).
- `arr_result`  in  ACC_W: array result.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: result consumed when both high.
- `res_data`  out  ACC_W: captured result.
- `busy`  out  1: state is CLEAR, RUN or HOLD.

## Operation
- Packing: element i occupies bits [(8-i)*DATA_W +: DATA_W]. Element 0 is in the MSBs, matching `{e0,e1,...,e8}` concatenation order.
- Kernel buffer: 9 registers plus a 9-bit written mask. `kernel_valid` is the AND of the mask.
- Kernel writes are accepted in LOAD and HOLD only. They are ignored in CLEAR and RUN. Addresses 9..15 are ignored.
- FSM states:
  - LOAD:
    - `win_ready = kernel_valid`.
    - Each accepted beat writes `win_buf[cnt]` and increments `cnt`.
    - An accepted beat with cnt==8 moves to CLEAR and resets cnt to 0.
  - CLEAR:
    - `arr_clr=1` for exactly one cycle.
    - Moves to RUN and loads `lat_cnt = ARRAY_LAT-1`.
  - RUN:
    - Decrements `lat_cnt`.
    - At 0, registers `arr_result` into `res_data`, sets `res_valid`, and moves to HOLD.
  - HOLD:
    - `res_valid=1`; `res_data` is stable.
    - When `res_ready` is high, clears `res_valid` and moves to LOAD.
- `arr_data_a` and `arr_data_k` are direct register outputs. The window buffer is written only in LOAD, so `arr_data_a` is stable from CLEAR through HOLD.
- No arithmetic in this block. `res_data` is a bit-exact copy of `arr_result`.

## Timing
- Reset values:
  - state LOAD, cnt 0, `lat_cnt` 0.
  - `win_ready` 0, `kernel_valid` 0, mask 0.
  - `arr_data_a`/`arr_data_k` 0, `arr_clr` 0.
  - `res_valid` 0, `res_data` 0, `busy` 0.
- `win_ready` and `busy` are decoded from registered state only; there is no combinational path from `win_valid` or `res_ready`.
- The 9th beat is accepted at cycle T. Then:
  - `arr_clr`=1 at T+1.
  - RUN occupies T+2..T+1+ARRAY_LAT.
  - `res_valid` rises at T+2+ARRAY_LAT.
  - `res_data` equals `arr_result` sampled at the last RUN cycle.
- Handshake accepted at cycle H in HOLD: `res_valid`=0 and `win_ready`=`kernel_valid` at H+1. This costs one bubble per window.
- A kernel write at cycle T is visible on `arr_data_k` and `kernel_valid` at T+1. A write and a window beat in the same LOAD cycle are both taken.
- A kernel rewrite of an already-written address keeps `kernel_valid`=1.
- `reset_n` asserted in any state returns all registers to reset values immediately. The partial window is discarded and the kernel must be rewritten.

## Structure
- `sys_array_pkg`:
  - DATA_W, N, ACC_W, ARRAY_LAT defaults.
  - `ctrl_state_t` enum {LOAD, CLEAR, RUN, HOLD}.
  - Element-slice helper function for the packing rule.
- Sub-module `coef_buf`: kernel registers, written mask, `kernel_valid`, and a write-enable gate input from the FSM.
- The window buffer, counters and FSM stay in `sys_array_ctrl`.

## Test plan
- Nominal run:
  - Stimulus: write kernel {1,0,-1,1,0,-1,1,0,-1}; stream 1..9 with `res_ready`=1; array model yields -6.
  - Required: `arr_data_a` = {16'd1,...,16'd9}; `arr_data_k` = {16'd1,16'd0,16'hFFFF,...}; one `arr_clr` pulse at T+1; `res_valid` at T+12; `res_data`=32'hFFFFFFFA.
- Kernel gate:
  - Stimulus: write only addresses 0..7, hold `win_valid`=1; then write address 8.
  - Required: `win_ready` stays 0 throughout; after the address-8 write, `kernel_valid` and `win_ready` are 1 on the next cycle.
- Backpressure:
  - Stimulus: `res_ready`=0 for 20 cycles after `res_valid`, then 1.
  - Required: `res_valid`/`res_data` held and `win_ready`=0 for the full 20 cycles; LOAD on the cycle after the handshake.
- Gapped stream:
  - Stimulus: `win_valid` toggles every cycle with data 10,11,...
  - Required: exactly 9 beats accepted, in order, with `arr_data_a` = {10..18}; the 10th value is not accepted before HOLD exits.
- Kernel write masking:
  - Stimulus: write addr 0 = 5 during RUN; then the same write during HOLD.
  - Required: `arr_data_k` is unchanged after the RUN write; after the HOLD write, `arr_data_k`[143:128]=5.
- Reset mid-run:
  - Stimulus: `reset_n` low at RUN cycle 4.
  - Required: all outputs at reset values at once, `kernel_valid`=0, and no `res_valid` pulse after release.
